// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush scheduler for the 5-stage MINI-RISC pipeline. It sits
// beside the decode-stage control unit and decides, every cycle, whether the
// PC, IF/ID and ID/EX registers advance, hold, flush or take a bubble.
//
// Handled situations, highest priority first while running:
//   - taken jump resolved in EX   -> flush IF/ID, bubble ID/EX
//   - load-use interlock          -> freeze PC and IF/ID for one cycle, bubble
//   - MUL/DIV entering EX         -> hold EX for MULDIV_CYCLES cycles in total
//   - HALT entering EX            -> freeze front end until a resume pulse
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   id_rs1/id_rs2  source registers of the instruction in ID
//   id_use_rs1/2   ID instruction actually reads rs1 / rs2
//   id_muldiv      ID instruction is MUL or DIV
//   id_halt        ID instruction is HALT
//   ex_rd          destination register of the instruction in EX
//   ex_mem_read    EX instruction is a LOAD
//   ex_jump_taken  jump/branch resolved taken in EX
//   resume         single-cycle pulse releasing the halted state
//   pc_write       PC update enable
//   if_id_write    IF/ID load enable
//   if_id_flush    IF/ID clear to NOP
//   id_ex_bubble   ID/EX loads a NOP
//   ex_hold        EX stage and ID/EX keep their contents
//   muldiv_busy    MUL/DIV occupies EX
//   halted         pipeline halted
//   stall_cycles   saturating count of stalled (non-halted) cycles
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W    = 3,
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_muldiv,
    input  logic                  id_halt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_jump_taken,
    input  logic                  resume,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_hold,
    output logic                  muldiv_busy,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cycles
);

    // The down-counter only has to reach MULDIV_CYCLES-1 <= 14.
    localparam int          MD_CNT_W = 4;
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MULDIV_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MULDIV = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [MD_CNT_W-1:0]  md_cnt;
    logic [MD_CNT_W-1:0]  md_cnt_next;

    // Decoded control before the reset override is applied.
    logic run_pc_write;
    logic run_if_id_write;
    logic run_if_id_flush;
    logic run_id_ex_bubble;
    logic run_ex_hold;
    logic run_muldiv_busy;
    logic run_halted;

    logic load_use;
    logic stall_inc;

    // ------------------------------------------------------------------------
    // Load-use hazard: the LOAD in EX produces a value that the ID
    // instruction needs next cycle, which forwarding cannot supply yet.
    // Register 0 is an ordinary register here, so no zero check.
    // ------------------------------------------------------------------------
    always_comb begin
        load_use = ex_mem_read &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // ------------------------------------------------------------------------
    // Next-state and control decode.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_next       = state;
        md_cnt_next      = md_cnt;
        run_pc_write     = 1'b1;
        run_if_id_write  = 1'b1;
        run_if_id_flush  = 1'b0;
        run_id_ex_bubble = 1'b0;
        run_ex_hold      = 1'b0;
        run_muldiv_busy  = 1'b0;
        run_halted       = 1'b0;

        unique case (state)
            ST_RUN: begin
                if (ex_jump_taken) begin
                    // The ID instruction is squashed, so its MUL/DIV or HALT
                    // decode must not start anything.
                    run_if_id_flush  = 1'b1;
                    run_id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    run_pc_write     = 1'b0;
                    run_if_id_write  = 1'b0;
                    run_id_ex_bubble = 1'b1;
                end else if (id_muldiv) begin
                    state_next  = ST_MULDIV;
                    md_cnt_next = MD_LOAD;
                end else if (id_halt) begin
                    state_next = ST_HALTED;
                end
            end

            ST_MULDIV: begin
                // The MUL/DIV already spent one EX cycle while still in RUN,
                // so the front end is frozen for MULDIV_CYCLES-1 cycles.
                run_pc_write    = 1'b0;
                run_if_id_write = 1'b0;
                run_ex_hold     = 1'b1;
                run_muldiv_busy = 1'b1;
                md_cnt_next     = md_cnt - 1'b1;
                if (md_cnt == MD_CNT_W'(1)) begin
                    state_next = ST_RUN;
                end
            end

            ST_HALTED: begin
                // Outputs keep the halted values even in the resume cycle;
                // the front end restarts on the following cycle.
                run_pc_write     = 1'b0;
                run_if_id_write  = 1'b0;
                run_id_ex_bubble = 1'b1;
                run_halted       = 1'b1;
                if (resume) begin
                    state_next = ST_RUN;
                end
            end

            default: begin
                state_next  = ST_RUN;
                md_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output stage. Reset is applied combinationally so the pipeline is
    // flushed and frozen the instant reset rises, not at the next edge.
    // ------------------------------------------------------------------------
    always_comb begin
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_hold      = 1'b0;
            muldiv_busy  = 1'b0;
            halted       = 1'b0;
        end else begin
            pc_write     = run_pc_write;
            if_id_write  = run_if_id_write;
            if_id_flush  = run_if_id_flush;
            id_ex_bubble = run_id_ex_bubble;
            ex_hold      = run_ex_hold;
            muldiv_busy  = run_muldiv_busy;
            halted       = run_halted;
        end
    end

    // Halted cycles are deliberate, not hazards, so they are not counted.
    always_comb begin
        stall_inc = !pc_write && (state != ST_HALTED);
    end

    // ------------------------------------------------------------------------
    // State, MUL/DIV down-counter and performance counter.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state  <= ST_RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall_inc && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

`ifndef SYNTHESIS
    // At most one of flush, hold and halted may be active in a cycle.
    always_comb begin
        assert ($onehot0({if_id_flush, ex_hold, halted}))
            else $error("flush/hold/halted overlap");
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed bench for pipeline_hazard_ctrl. Two instances share stimulus: the
// default-width one and a CNT_W=4 one used for the saturation case.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit later, well before the next edge.
// Control vector layout used in checks:
//   {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, muldiv_busy, halted}
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, id_muldiv, id_halt;
    logic       ex_mem_read, ex_jump_taken, resume;

    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic        ex_hold, muldiv_busy, halted;
    logic [15:0] stall_cycles;

    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble;
    logic        s_ex_hold, s_muldiv_busy, s_halted;
    logic [3:0]  s_stall_cycles;

    int passed = 0;
    int total  = 0;

    localparam logic [6:0] C_RESET  = 7'b0011000;
    localparam logic [6:0] C_RUN    = 7'b1100000;
    localparam logic [6:0] C_LU     = 7'b0001000;
    localparam logic [6:0] C_JUMP   = 7'b1111000;
    localparam logic [6:0] C_MULDIV = 7'b0000110;
    localparam logic [6:0] C_HALTED = 7'b0001001;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(3), .MULDIV_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_muldiv(id_muldiv), .id_halt(id_halt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_jump_taken(ex_jump_taken), .resume(resume),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .ex_hold(ex_hold), .muldiv_busy(muldiv_busy), .halted(halted),
        .stall_cycles(stall_cycles)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(3), .MULDIV_CYCLES(4), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_muldiv(id_muldiv), .id_halt(id_halt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_jump_taken(ex_jump_taken), .resume(resume),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write),
        .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble),
        .ex_hold(s_ex_hold), .muldiv_busy(s_muldiv_busy), .halted(s_halted),
        .stall_cycles(s_stall_cycles)
    );

    function automatic logic [6:0] ctrl();
        return {pc_write, if_id_write, if_id_flush, id_ex_bubble,
                ex_hold, muldiv_busy, halted};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_muldiv = 0; id_halt = 0;
        ex_mem_read = 0; ex_jump_taken = 0; resume = 0;
    endtask

    task automatic drive_load_use();
        ex_mem_read = 1; ex_rd = 3'd3; id_use_rs2 = 1; id_rs2 = 3'd3;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1;
        check("reset_ctrl", 32'(ctrl()), 32'(C_RESET));
        check("reset_stall", 32'(stall_cycles), 0);
        tick(); tick();
        reset = 1'b0;
        #1;
        check("run_idle", 32'(ctrl()), 32'(C_RUN));

        // Load-use on rs2: exactly one stall cycle.
        drive_load_use();
        #1;
        check("lu_rs2_ctrl", 32'(ctrl()), 32'(C_LU));
        tick();
        clear_inputs();
        #1;
        check("lu_rs2_after", 32'(ctrl()), 32'(C_RUN));
        check("lu_rs2_stall", 32'(stall_cycles), 1);

        // Same pattern but rs2 not used: no stall.
        drive_load_use(); id_use_rs2 = 0;
        #1;
        check("lu_unused_ctrl", 32'(ctrl()), 32'(C_RUN));
        tick();
        // Match on rs1 against register 0 (not special).
        clear_inputs();
        ex_mem_read = 1; ex_rd = 3'd0; id_use_rs1 = 1; id_rs1 = 3'd0;
        #1;
        check("lu_rs1_r0_ctrl", 32'(ctrl()), 32'(C_LU));
        tick();
        // Register match without a load: no stall.
        clear_inputs();
        ex_rd = 3'd5; id_use_rs1 = 1; id_rs1 = 3'd5;
        #1;
        check("no_load_ctrl", 32'(ctrl()), 32'(C_RUN));
        tick();
        clear_inputs();
        #1;
        check("lu_total_stall", 32'(stall_cycles), 2);

        // Jump beats load-use and halt.
        drive_load_use(); id_halt = 1; ex_jump_taken = 1;
        #1;
        check("jump_ctrl", 32'(ctrl()), 32'(C_JUMP));
        tick();
        clear_inputs();
        #1;
        check("jump_after", 32'(ctrl()), 32'(C_RUN));
        check("jump_stall", 32'(stall_cycles), 2);

        // MUL/DIV: three frozen cycles, ignore jump/halt/resume mid-way.
        id_muldiv = 1;
        #1;
        check("md_issue", 32'(ctrl()), 32'(C_RUN));
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                ex_jump_taken = 1; id_halt = 1; resume = 1;
            end
            #1;
            check($sformatf("md_busy%0d", i), 32'(ctrl()), 32'(C_MULDIV));
            tick();
            clear_inputs();
        end
        #1;
        check("md_done", 32'(ctrl()), 32'(C_RUN));
        check("md_stall", 32'(stall_cycles), 5);

        // HALT: halted for 10 cycles, counter frozen.
        id_halt = 1;
        #1;
        check("halt_issue", 32'(ctrl()), 32'(C_RUN));
        tick();
        clear_inputs();
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("halted%0d", i), 32'(ctrl()), 32'(C_HALTED));
            tick();
        end
        check("halt_stall", 32'(stall_cycles), 5);
        resume = 1;
        #1;
        check("resume_cycle", 32'(ctrl()), 32'(C_HALTED));
        tick();
        resume = 0;
        #1;
        check("resumed", 32'(ctrl()), 32'(C_RUN));
        check("resume_stall", 32'(stall_cycles), 5);
        // resume while running does nothing.
        resume = 1;
        #1;
        check("resume_in_run", 32'(ctrl()), 32'(C_RUN));
        tick();
        resume = 0;

        // Async reset mid-MULDIV with counter at 2.
        id_muldiv = 1;
        tick();              // now MULDIV, counter 3
        clear_inputs();
        tick();              // counter 2, one stall counted
        #1;
        check("pre_reset_busy", 32'(muldiv_busy), 1);
        check("pre_reset_stall", 32'(stall_cycles), 6);
        reset = 1'b1;
        #1;
        check("async_reset_ctrl", 32'(ctrl()), 32'(C_RESET));
        check("async_reset_stall", 32'(stall_cycles), 0);
        tick();
        reset = 1'b0;
        #1;
        check("post_reset_ctrl", 32'(ctrl()), 32'(C_RUN));
        tick();
        check("post_reset_run", 32'(ctrl()), 32'(C_RUN));
        check("post_reset_stall", 32'(stall_cycles), 0);

        // Saturation: 20 consecutive load-use stalls.
        drive_load_use();
        for (int i = 0; i < 15; i++) tick();
        check("sat_at15", 32'(s_stall_cycles), 15);
        for (int i = 0; i < 5; i++) tick();
        clear_inputs();
        #1;
        check("sat_hold", 32'(s_stall_cycles), 15);
        check("wide_count20", 32'(stall_cycles), 20);
        check("sat_ctrl", 32'({s_pc_write, s_halted}), 32'(2'b10));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
